// File: rtl/coin_pulse_shaper.sv
// Debounces, queues and replays coin requests as fixed-width pulses
// with a guaranteed low gap. Both channels are independent.
//
// Ports:
//   clk_sys            system clock (core clock_18)
//   reset_n            asynchronous active-low reset
//   pause              freezes pulse/gap timing (queue keeps filling)
//   coin_in[1:0]       raw coin buttons, bit0 = P1, bit1 = P2
//   coin_out[1:0]      shaped coin pulses to the core
//   pending1/pending2  queue depth of channel 0 / channel 1
//   drop[1:0]          one-cycle strobe when a coin hits a full queue
module coin_pulse_shaper #(
  parameter int DEB_CYCLES   = 18000,
  parameter int PULSE_CYCLES = 1800000,
  parameter int GAP_CYCLES   = 1800000,
  parameter int QUEUE_MAX    = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pause,
  input  logic [1:0] coin_in,
  output logic [1:0] coin_out,
  output logic [1:0] pending1,
  output logic [1:0] pending2,
  output logic [1:0] drop
);

  localparam int DW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int MAXC =
    (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW =
    (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PLS_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [1:0]    QMAX     = 2'(QUEUE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } st_e;

  logic [1:0] pend [2];

  assign pending1 = pend[0];
  assign pending2 = pend[1];

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          in_q;
    logic          filt_q, filt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          rise;
    logic          enq, deq;
    logic [1:0]    pend_q, pend_d;
    logic          drop_q, drop_d;
    st_e           state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          coin_q, coin_d;

    // Filter toggles on the edge where the mismatch run
    // would reach DEB_CYCLES.
    always_comb begin
      filt_d = filt_q;
      dcnt_d = '0;
      rise   = 1'b0;
      if (in_q != filt_q) begin
        if (dcnt_q == DEB_LAST) begin
          filt_d = ~filt_q;
          rise   = ~filt_q;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
    end

    // Full check uses the depth before any same-edge dequeue.
    always_comb begin
      enq    = rise && (pend_q < QMAX);
      drop_d = rise && (pend_q >= QMAX);
      deq    = (state_q == IDLE) && (pend_q != 2'd0) && !pause;
      pend_d = pend_q;
      unique case (1'b1)
        enq && !deq: pend_d = pend_q + 2'd1;
        deq && !enq: pend_d = pend_q - 2'd1;
        default:     pend_d = pend_q;
      endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        in_q   <= 1'b0;
        filt_q <= 1'b0;
        dcnt_q <= '0;
        pend_q <= 2'd0;
        drop_q <= 1'b0;
      end else begin
        in_q   <= coin_in[i];
        filt_q <= filt_d;
        dcnt_q <= dcnt_d;
        pend_q <= pend_d;
        drop_q <= drop_d;
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        coin_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        coin_q  <= coin_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE: begin
          if (deq) begin
            state_d = PULSE;
            cnt_d   = PLS_LAST;
          end
        end
        PULSE: begin
          if (!pause) begin
            if (cnt_q == '0) begin
              state_d = GAP;
              cnt_d   = GAP_LAST;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        GAP: begin
          if (!pause) begin
            if (cnt_q == '0) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      coin_d = (state_d == PULSE);
    end

    assign coin_out[i] = coin_q;
    assign drop[i]     = drop_q;
    assign pend[i]     = pend_q;
  end

endmodule

// File: doc/coin_pulse_shaper.md
# coin_pulse_shaper

Input conditioning stage that sits between the hps_io joystick decode and the Xevious core's `coin1`/`coin2` inputs. Each coin request is debounced, queued, and replayed to the core as a fixed-width coin pulse with a guaranteed low gap, so the game's coin counter logic registers every coin exactly once. The queue keeps filling while the core is paused. Pulse replay resumes when the pause is released. Both channels are identical and fully independent.

## Interface

Parameters:
- `DEB_CYCLES`, 18000 — consecutive cycles a raw level must persist before the filtered level follows. 1 ms at 18 MHz; minimum 1.
- `PULSE_CYCLES`, 1800000 — high width of each output coin pulse in cycles (100 ms); minimum 1.
- `GAP_CYCLES`, 1800000 — minimum low time after each pulse before the next pulse may start; minimum 1.
- `QUEUE_MAX`, 3 — maximum pending coins per channel; range 1..3.

Ports:
- `clk_sys`  in  1 — system clock, same as the core's `clock_18`.
- `reset_n`  in  1 — reset, asynchronous, active-low.
- `pause`  in  1 — from the pause/hiscore logic; freezes pulse/gap timing.
- `coin_in`  in  2 — raw coin buttons, active-high. Bit 0 is P1 and bit 1 is P2. Already synchronous to `clk_sys`.
- `coin_out`  out  2 — shaped coin pulses to the core, active-high.
- `pending1`, `pending2`  out  2 each — current queue depth per channel.
- `drop`  out  2 — one-cycle strobe per channel when a coin is discarded because the queue is full.

## Operation

The following pipeline runs independently on each channel.

Input register:
- `in_r <= coin_in[i]` on every edge, with no further synchronizer.

Debounce:
- `filt` is the filtered level.
- `dcnt` counts consecutive edges at which `in_r != filt`. It clears to 0 on any edge where they are equal.
- When `dcnt` would reach `DEB_CYCLES`, `filt` toggles on that edge and `dcnt` clears.
- Debounce keeps running during `pause`.

Enqueue:
- Occurs on the same edge that `filt` goes 0→1.
- If `pending < QUEUE_MAX`, `pending` increments.
- Otherwise `pending` is unchanged and `drop[i]` is high for the following cycle only.
- A 1→0 transition of `filt` produces no event.

FSM states: IDLE, PULSE, GAP. The counter `cnt` is 21 bits and is sized from the largest parameter.
- IDLE: if `pending != 0` and `!pause`, go to PULSE, decrement `pending`, set `cnt = PULSE_CYCLES-1`.
- PULSE: if `cnt == 0`, go to GAP with `cnt = GAP_CYCLES-1`. Otherwise `cnt--`. No counting occurs while `pause` is high.
- GAP: if `cnt == 0`, go to IDLE. Otherwise `cnt--`. No counting occurs while `pause` is high.
- `coin_out[i]` is registered and is high exactly while in PULSE. It stays high if `pause` asserts mid-pulse.

Simultaneous enqueue and dequeue on the same edge leaves `pending` unchanged. `drop` is evaluated against `pending` before the dequeue.

## Timing

Reset (`reset_n` low, asynchronous):
- `in_r`, `filt`, `dcnt`, `cnt`, `pending` = 0; state = IDLE; `coin_out` = 0; `drop` = 0.
- The block must restart cleanly if reset asserts mid-pulse.

Latency:
- Edge E0 is the first edge that samples `coin_in` high; the input then stays high.
- `filt` rises and the coin enqueues at edge E0+`DEB_CYCLES`.
- `coin_out` rises at edge E0+`DEB_CYCLES`+1, provided the queue was empty, the state was IDLE and `pause` was low.

Pulse and gap widths:
- `coin_out` is high for exactly `PULSE_CYCLES` cycles in the absence of pause.
- After each pulse, `coin_out` is low for at least `GAP_CYCLES`+1 cycles before the next pulse: GAP plus the IDLE decision edge.

Rejection and release:
- A raw pulse or glitch shorter than `DEB_CYCLES` cycles never changes `filt`.
- After a long press, release needs `DEB_CYCLES` low cycles before a new press can enqueue.
- On `pause` deassert, FSM counting resumes on the next edge, with no lost or extra cycles.

## Test plan

All scenarios use parameters DEB=4, PULSE=8, GAP=6, QUEUE_MAX=3.

- Reset and single coin: hold `reset_n`=0, release, then drive `coin_in`=01 from E0 for 10 cycles. Expect `pending1` to reach 1 at E0+4 and `coin_out[0]` to rise at E0+5. The output then stays high for 8 cycles and `pending1` returns to 0. All other outputs remain 0.
- Glitch rejection: drive `coin_in[1]` high for 3 cycles, low for 1, high for 3. Expect no enqueue, `coin_out[1]` never high and `pending2` staying 0.
- Queue overflow: give 5 debounced presses, each 5 high / 5 low, on channel 0 during `pause`=1. Expect `pending1` to saturate at 3, `drop[0]` to strobe twice and `coin_out[0]` to stay 0. After `pause`=0, expect exactly 3 pulses of 8 cycles with gaps of ≥7 cycles.
- Pause mid-pulse: assert `pause` at cycle 3 of a pulse for 20 cycles. Expect `coin_out` to stay high throughout and the total high time to be 8+20 cycles.
- Simultaneous enqueue/dequeue: time an enqueue to the IDLE→PULSE edge with `pending`=1. Expect `pending` to remain 1 and no drop.
- Async reset mid-GAP: pull `reset_n` low between edges. Expect all outputs to be 0 immediately without waiting for an edge, and the queue to be cleared.
